jtag_tap_sync: RTL and testbench

Oversampled IEEE 1149.1 TAP controller that consumes the JTAG pin stream produced by the DPI JTAG bridge (TMS/TCK/TRST/TDI) and returns TDO to it. TCK is treated as data: all pins are synchronised into the system clock domain, TCK edges are detected, and the 16-state TAP FSM, instruction register, IDCODE, BYPASS and one user data register advance on those detected edges. It is the first on-chip stage behind the JTAG pins and feeds the debug unit through the user-DR capture/update interface.

---
 rtl/jtag_tap_pkg.sv | 52 +++++
 rtl/jtag_sync.sv | 52 +++++
 rtl/jtag_tap_sync.sv | 128 ++++++++++++
 tb/tb_jtag_tap_sync.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: state encoding, instruction opcodes and the 1149.1 state graph.
package jtag_tap_pkg;

    typedef enum logic [3:0] {
        TAP_TLR       = 4'h0,
        TAP_RTI       = 4'h1,
        TAP_SEL_DR    = 4'h2,
        TAP_CAPTURE_DR = 4'h3,
        TAP_SHIFT_DR  = 4'h4,
        TAP_EXIT1_DR  = 4'h5,
        TAP_PAUSE_DR  = 4'h6,
        TAP_EXIT2_DR  = 4'h7,
        TAP_UPDATE_DR = 4'h8,
        TAP_SEL_IR    = 4'h9,
        TAP_CAPTURE_IR = 4'hA,
        TAP_SHIFT_IR  = 4'hB,
        TAP_EXIT1_IR  = 4'hC,
        TAP_PAUSE_IR  = 4'hD,
        TAP_EXIT2_IR  = 4'hE,
        TAP_UPDATE_IR = 4'hF
    } tap_state_e;

    localparam logic [4:0] INSTR_IDCODE = 5'b00001;
    localparam logic [4:0] INSTR_USER   = 5'b01000;
    localparam logic [4:0] INSTR_BYPASS = 5'b11111;

    function automatic tap_state_e tap_next_state(input tap_state_e s, input logic tms);
        tap_state_e n;
        n = TAP_TLR;
        case (s)
            TAP_TLR:        n = tms ? TAP_TLR       : TAP_RTI;
            TAP_RTI:        n = tms ? TAP_SEL_DR    : TAP_RTI;
            TAP_SEL_DR:     n = tms ? TAP_SEL_IR    : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR: n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_SHIFT_DR:   n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_EXIT1_DR:   n = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR:   n = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
            TAP_EXIT2_DR:   n = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR:  n = tms ? TAP_SEL_DR    : TAP_RTI;
            TAP_SEL_IR:     n = tms ? TAP_TLR       : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR: n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_SHIFT_IR:   n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_EXIT1_IR:   n = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:   n = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
            TAP_EXIT2_IR:   n = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            TAP_UPDATE_IR:  n = tms ? TAP_SEL_DR    : TAP_RTI;
            default:        n = TAP_TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_sync.sv
// Brings the four JTAG pins into the system clock domain and turns TCK into rise/fall strobes.
module jtag_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tck,
    input  logic i_tms,
    input  logic i_tdi,
    input  logic i_trst_n,
    output logic o_tck_rise,
    output logic o_tck_fall,
    output logic o_tms,
    output logic o_tdi,
    output logic o_trst_n
);

    logic r_tckMeta, r_tckSync, r_tckPrev;
    logic r_tmsMeta, r_tmsSync;
    logic r_tdiMeta, r_tdiSync;
    logic r_trstMeta, r_trstSync;

    // TRST resets to 0 so the TAP sits in Test-Logic-Reset until the pin is seen high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tckMeta  <= 1'b0;
            r_tckSync  <= 1'b0;
            r_tckPrev  <= 1'b0;
            r_tmsMeta  <= 1'b0;
            r_tmsSync  <= 1'b0;
            r_tdiMeta  <= 1'b0;
            r_tdiSync  <= 1'b0;
            r_trstMeta <= 1'b0;
            r_trstSync <= 1'b0;
        end else begin
            r_tckMeta  <= i_tck;
            r_tckSync  <= r_tckMeta;
            r_tckPrev  <= r_tckSync;
            r_tmsMeta  <= i_tms;
            r_tmsSync  <= r_tmsMeta;
            r_tdiMeta  <= i_tdi;
            r_tdiSync  <= r_tdiMeta;
            r_trstMeta <= i_trst_n;
            r_trstSync <= r_trstMeta;
        end
    end

    assign o_tck_rise = r_tckSync & ~r_tckPrev;
    assign o_tck_fall = ~r_tckSync & r_tckPrev;
    assign o_tms      = r_tmsSync;
    assign o_tdi      = r_tdiSync;
    assign o_trst_n   = r_trstSync;

endmodule

// File: rtl/jtag_tap_sync.sv
// Oversampled 1149.1 TAP: TCK is sampled as data and the TAP advances on detected TCK edges.
module jtag_tap_sync
    import jtag_tap_pkg::*;
#(
    parameter int unsigned IR_WIDTH     = 5,
    parameter int unsigned DR_WIDTH     = 32,
    parameter logic [31:0] IDCODE_VALUE = 32'h149511C3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                jtag_tck_i,
    input  logic                jtag_tms_i,
    input  logic                jtag_trst_ni,
    input  logic                jtag_tdi_i,
    output logic                jtag_tdo_o,
    input  logic [DR_WIDTH-1:0] user_capture_data_i,
    output logic                user_update_valid_o,
    output logic [DR_WIDTH-1:0] user_update_data_o,
    output logic [IR_WIDTH-1:0] ir_o,
    output logic [3:0]          tap_state_o
);

    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(INSTR_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(INSTR_USER);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-2){1'b0}}, 2'b01};

    logic w_tckRise, w_tckFall, w_tms, w_tdi, w_trstN;
    logic w_selIdcode, w_selUser, w_drLsb;

    tap_state_e          r_state;
    logic [IR_WIDTH-1:0] r_irShift;
    logic [IR_WIDTH-1:0] r_ir;
    logic [31:0]         r_idcodeShift;
    logic                r_bypass;
    logic [DR_WIDTH-1:0] r_userShift;
    logic                r_tdo;
    logic                r_updValid;
    logic [DR_WIDTH-1:0] r_updData;

    jtag_sync u_sync (
        .i_clk      (clk_i),
        .i_rst_n    (rst_ni),
        .i_tck      (jtag_tck_i),
        .i_tms      (jtag_tms_i),
        .i_tdi      (jtag_tdi_i),
        .i_trst_n   (jtag_trst_ni),
        .o_tck_rise (w_tckRise),
        .o_tck_fall (w_tckFall),
        .o_tms      (w_tms),
        .o_tdi      (w_tdi),
        .o_trst_n   (w_trstN)
    );

    // Unrecognised instructions fall through to BYPASS.
    assign w_selIdcode = (r_ir == IR_IDCODE);
    assign w_selUser   = (r_ir == IR_USER);
    assign w_drLsb     = w_selIdcode ? r_idcodeShift[0] :
                         w_selUser   ? r_userShift[0]   : r_bypass;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= TAP_TLR;
            r_ir       <= IR_IDCODE;
            r_tdo      <= 1'b0;
            r_updValid <= 1'b0;
            r_updData  <= '0;
        end else if (!w_trstN) begin
            r_state    <= TAP_TLR;
            r_ir       <= IR_IDCODE;
            r_updValid <= 1'b0;
        end else begin
            r_updValid <= 1'b0;
            if (w_tckRise) begin
                r_state <= tap_next_state(r_state, w_tms);
            end
            if (w_tckFall) begin
                case (r_state)
                    TAP_SHIFT_IR:  r_tdo <= r_irShift[0];
                    TAP_SHIFT_DR:  r_tdo <= w_drLsb;
                    TAP_UPDATE_IR: r_ir  <= r_irShift;
                    TAP_UPDATE_DR: begin
                        if (w_selUser) begin
                            r_updValid <= 1'b1;
                            r_updData  <= r_userShift;
                        end
                    end
                    default: ;
                endcase
            end
            if (r_state == TAP_TLR) begin
                r_ir <= IR_IDCODE;
            end
        end
    end

    // Capture and shift happen on the rise that leaves Capture/Shift, matching 1149.1 timing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irShift     <= '0;
            r_idcodeShift <= '0;
            r_bypass      <= 1'b0;
            r_userShift   <= '0;
        end else if (w_trstN && w_tckRise) begin
            case (r_state)
                TAP_CAPTURE_IR: r_irShift <= IR_CAPTURE;
                TAP_SHIFT_IR:   r_irShift <= {w_tdi, r_irShift[IR_WIDTH-1:1]};
                TAP_CAPTURE_DR: begin
                    if (w_selIdcode)    r_idcodeShift <= IDCODE_VALUE;
                    else if (w_selUser) r_userShift   <= user_capture_data_i;
                    else                r_bypass      <= 1'b0;
                end
                TAP_SHIFT_DR: begin
                    if (w_selIdcode)    r_idcodeShift <= {w_tdi, r_idcodeShift[31:1]};
                    else if (w_selUser) r_userShift   <= {w_tdi, r_userShift[DR_WIDTH-1:1]};
                    else                r_bypass      <= w_tdi;
                end
                default: ;
            endcase
        end
    end

    assign jtag_tdo_o          = r_tdo;
    assign user_update_valid_o = r_updValid;
    assign user_update_data_o  = r_updData;
    assign ir_o                = r_ir;
    assign tap_state_o         = r_state;

endmodule

// File: tb/tb_jtag_tap_sync.sv
// Directed bench for jtag_tap_sync: bit-bangs TCK slowly and checks TDO, IR and the user update pulse.
module tb_jtag_tap_sync;

    logic        clk;
    logic        rstN;
    logic        tck;
    logic        tms;
    logic        trstN;
    logic        tdi;
    logic        tdo;
    logic [31:0] userCapture;
    logic        updValid;
    logic [31:0] updData;
    logic [4:0]  irOut;
    logic [3:0]  tapState;

    int checks;
    int errors;
    int pulseCount;
    int pulseCycles;
    logic        prevValid;
    logic [31:0] lastPulseData;

    jtag_tap_sync dut (
        .clk_i               (clk),
        .rst_ni              (rstN),
        .jtag_tck_i          (tck),
        .jtag_tms_i          (tms),
        .jtag_trst_ni        (trstN),
        .jtag_tdi_i          (tdi),
        .jtag_tdo_o          (tdo),
        .user_capture_data_i (userCapture),
        .user_update_valid_o (updValid),
        .user_update_data_o  (updData),
        .ir_o                (irOut),
        .tap_state_o         (tapState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts update pulses and how many cycles they stay high.
    always @(negedge clk) begin
        if (updValid) begin
            pulseCycles++;
            lastPulseData = updData;
            if (!prevValid) pulseCount++;
        end
        prevValid = updValid;
    end

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic tck_cycle(input logic tmsVal, input logic tdiVal, output logic tdoVal);
        tms = tmsVal;
        tdi = tdiVal;
        waitCycles(2);
        tck = 1'b1;
        waitCycles(5);
        tck = 1'b0;
        waitCycles(5);
        tdoVal = tdo;
    endtask

    // From RTI, walks to Shift-DR or Shift-IR; returns the first TDO bit.
    task automatic enter_shift(input logic isIr, output logic firstTdo);
        logic t;
        tck_cycle(1'b1, 1'b0, t);
        if (isIr) tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        tck_cycle(1'b0, 1'b0, firstTdo);
    endtask

    // Shifts n bits LSB-first, leaving the TAP in Exit1; dout[0] must already hold the first bit.
    task automatic shift_bits(input logic [31:0] din, input int n, inout logic [31:0] dout);
        logic t;
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, din[i], t);
            if (i < n - 1) dout[i+1] = t;
        end
    endtask

    task automatic scan(input logic isIr, input logic [31:0] din, input int n, output logic [31:0] dout);
        logic t;
        dout = '0;
        enter_shift(isIr, t);
        dout[0] = t;
        shift_bits(din, n, dout);
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
    endtask

    task automatic test_reset;
        rstN = 1'b0; trstN = 1'b1; tck = 1'b0; tms = 1'b0; tdi = 1'b0;
        userCapture = 32'h0;
        waitCycles(3);
        checks += 5;
        if (tdo !== 1'b0)         begin errors++; $display("[TB] FAIL reset_tdo: got %b expected 0", tdo); end
        if (tapState !== 4'h0)    begin errors++; $display("[TB] FAIL reset_state: got %h expected 0", tapState); end
        if (irOut !== 5'b00001)   begin errors++; $display("[TB] FAIL reset_ir: got %b expected 00001", irOut); end
        if (updValid !== 1'b0)    begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", updValid); end
        if (updData !== 32'h0)    begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", updData); end
        rstN = 1'b1;
        waitCycles(4);
    endtask

    task automatic test_idcode;
        logic [31:0] d;
        logic t;
        tck_cycle(1'b0, 1'b0, t);
        scan(1'b0, 32'h0, 32, d);
        checks++;
        if (d !== 32'h149511C3) begin errors++; $display("[TB] FAIL idcode: got %h expected 149511c3", d); end
    endtask

    task automatic test_bypass;
        logic [31:0] d;
        logic [4:0]  codes [2];
        codes[0] = 5'b11111;
        codes[1] = 5'b00111;
        for (int k = 0; k < 2; k++) begin
            scan(1'b1, {27'h0, codes[k]}, 5, d);
            checks++;
            if (irOut !== codes[k]) begin errors++; $display("[TB] FAIL bypass_ir%0d: got %b expected %b", k, irOut, codes[k]); end
            scan(1'b0, 32'h0000000D, 4, d);
            checks++;
            if (d[3:0] !== 4'b1010) begin errors++; $display("[TB] FAIL bypass_tdo%0d: got %b expected 1010", k, d[3:0]); end
        end
    endtask

    task automatic test_ir_capture;
        logic [31:0] d;
        logic t;
        d = '0;
        enter_shift(1'b1, t);
        d[0] = t;
        shift_bits(32'h00000008, 5, d);
        checks += 3;
        if (d[1:0] !== 2'b01)     begin errors++; $display("[TB] FAIL ir_capture_first2: got %b expected 01", d[1:0]); end
        if (d[4:0] !== 5'b00001)  begin errors++; $display("[TB] FAIL ir_capture_all: got %b expected 00001", d[4:0]); end
        if (irOut !== 5'b00111)   begin errors++; $display("[TB] FAIL ir_hold_before_update: got %b expected 00111", irOut); end
        tck_cycle(1'b1, 1'b0, t);
        checks++;
        if (irOut !== 5'b01000)   begin errors++; $display("[TB] FAIL ir_after_update: got %b expected 01000", irOut); end
        tck_cycle(1'b0, 1'b0, t);
    endtask

    task automatic test_user;
        logic [31:0] d;
        int p0, c0;
        p0 = pulseCount;
        c0 = pulseCycles;
        userCapture = 32'hDEADBEEF;
        scan(1'b0, 32'h12345678, 32, d);
        checks += 4;
        if (d !== 32'hDEADBEEF)          begin errors++; $display("[TB] FAIL user_tdo: got %h expected deadbeef", d); end
        if (pulseCount - p0 !== 1)       begin errors++; $display("[TB] FAIL user_pulse_count: got %0d expected 1", pulseCount - p0); end
        if (pulseCycles - c0 !== 1)      begin errors++; $display("[TB] FAIL user_pulse_width: got %0d expected 1", pulseCycles - c0); end
        if (lastPulseData !== 32'h12345678) begin errors++; $display("[TB] FAIL user_update_data: got %h expected 12345678", lastPulseData); end
    endtask

    task automatic test_tms_reset;
        logic [31:0] d;
        logic t;
        int p0;
        scan(1'b1, 32'h00000007, 5, d);
        p0 = pulseCount;
        enter_shift(1'b0, t);
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, t);
        checks += 3;
        if (tapState !== 4'h0)       begin errors++; $display("[TB] FAIL tms_reset_state: got %h expected 0", tapState); end
        if (irOut !== 5'b00001)      begin errors++; $display("[TB] FAIL tms_reset_ir: got %b expected 00001", irOut); end
        if (pulseCount !== p0)       begin errors++; $display("[TB] FAIL tms_reset_pulse: got %0d expected %0d", pulseCount, p0); end
        tck_cycle(1'b0, 1'b0, t);
    endtask

    task automatic test_trst;
        logic [31:0] d;
        logic t;
        int p0, waited;
        scan(1'b1, 32'h00000008, 5, d);
        p0 = pulseCount;
        enter_shift(1'b0, t);
        for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1, t);
        checks++;
        if (tapState === 4'h0) begin errors++; $display("[TB] FAIL trst_pre_state: got %h expected nonzero", tapState); end
        trstN = 1'b0;
        waited = 0;
        while (tapState !== 4'h0 && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        checks += 3;
        if (tapState !== 4'h0 || waited > 3) begin errors++; $display("[TB] FAIL trst_to_tlr: got state %h after %0d cycles expected 0 within 3", tapState, waited); end
        if (irOut !== 5'b00001)  begin errors++; $display("[TB] FAIL trst_ir: got %b expected 00001", irOut); end
        waitCycles(3);
        if (pulseCount !== p0)   begin errors++; $display("[TB] FAIL trst_pulse: got %0d expected %0d", pulseCount, p0); end
        trstN = 1'b1;
        waitCycles(4);
        tck_cycle(1'b0, 1'b0, t);
    endtask

    task automatic test_rst_n;
        logic [31:0] d;
        logic t;
        int p0;
        scan(1'b1, 32'h00000008, 5, d);
        enter_shift(1'b0, t);
        p0 = pulseCount;
        checks++;
        if (t !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_tdo: got %b expected 1", t); end
        rstN = 1'b0;
        #1;
        checks += 6;
        if (tdo !== 1'b0)        begin errors++; $display("[TB] FAIL rst_tdo: got %b expected 0", tdo); end
        if (tapState !== 4'h0)   begin errors++; $display("[TB] FAIL rst_state: got %h expected 0", tapState); end
        if (irOut !== 5'b00001)  begin errors++; $display("[TB] FAIL rst_ir: got %b expected 00001", irOut); end
        if (updValid !== 1'b0)   begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", updValid); end
        if (updData !== 32'h0)   begin errors++; $display("[TB] FAIL rst_data: got %h expected 0", updData); end
        waitCycles(2);
        if (pulseCount !== p0)   begin errors++; $display("[TB] FAIL rst_pulse: got %0d expected %0d", pulseCount, p0); end
        rstN = 1'b1;
        waitCycles(4);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pulseCount = 0;
        pulseCycles = 0;
        prevValid = 1'b0;
        lastPulseData = '0;
        test_reset();
        test_idcode();
        test_bypass();
        test_ir_capture();
        test_user();
        test_tms_reset();
        test_trst();
        test_rst_n();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
